// File: rtl/code_sel_seq.sv
// code_sel_seq: registered N-way code selector with a direct (host-selected,
// load-strobed) capture mode and an auto-scan (round-robin, fixed dwell) mode.
// The captured code sits in a valid/ready output register.
// Optional feature: define CODE_SEL_PARITY_EN to add o_parity, the XOR-reduce
// of the captured code, registered alongside o_code.
module code_sel_seq #(
    parameter int N_CODES = 4,
    parameter int CODE_W  = 8,
    parameter int SEL_W   = 2,
    parameter int DWELL   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_mode,
    input  logic [N_CODES*CODE_W-1:0] i_codes,
    input  logic [SEL_W-1:0]          i_sel_code,
    input  logic                      i_load,
    input  logic                      i_ready,
    output logic [CODE_W-1:0]         o_code,
    output logic                      o_valid,
    output logic [SEL_W-1:0]          o_sel_cur,
    output logic                      o_err,
`ifdef CODE_SEL_PARITY_EN
    output logic                      o_parity,
`endif
    output logic                      o_drop
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIRECT = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CODES - 1);

    logic [1:0]        state_q, state_cur;
    logic              state_chg, scan_entry;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff;
    logic [SEL_W-1:0]  ptr_q, ptr_d, ptr_eff;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic              slot_free;
    logic              sel_oob;
    logic [CODE_W-1:0] sel_code, scan_code;
    logic              dir_cap, scan_last, scan_cap, cap;

    // Operating state follows the enables in the current cycle; state_q only
    // remembers last cycle's state so transitions can be detected.
    always_comb begin
        if (!i_en)       state_cur = IDLE;
        else if (i_mode) state_cur = SCAN;
        else             state_cur = DIRECT;
    end

    assign state_chg  = (state_cur != state_q);
    assign scan_entry = state_chg && (state_cur == SCAN);
    // On a transition the counter (and, on scan entry, the pointer) act as
    // already cleared, so the first scan cycle counts as dwell slot 0.
    assign cnt_eff    = state_chg ? '0 : cnt_q;
    assign ptr_eff    = scan_entry ? '0 : ptr_q;
    assign slot_free  = !valid_q || i_ready;
    assign sel_oob    = int'(i_sel_code) >= N_CODES;

    // Channel muxes written as loops so an out-of-range select never indexes
    // past the packed input vector.
    always_comb begin
        sel_code  = '0;
        scan_code = '0;
        for (int k = 0; k < N_CODES; k++) begin
            if (i_sel_code == SEL_W'(k)) sel_code  = i_codes[k*CODE_W +: CODE_W];
            if (ptr_eff == SEL_W'(k))    scan_code = i_codes[k*CODE_W +: CODE_W];
        end
    end

    assign dir_cap   = (state_cur == DIRECT) && i_load && slot_free;
    assign scan_last = (state_cur == SCAN) && (cnt_eff == CNT_LAST);
    assign scan_cap  = scan_last && slot_free;
    assign cap       = dir_cap || scan_cap;

    // Dwell counter and scan pointer next state; a blocked capture stalls both.
    always_comb begin
        cnt_d = cnt_eff;
        ptr_d = ptr_q;
        if (state_cur == SCAN) begin
            ptr_d = ptr_eff;
            if (scan_last) begin
                if (slot_free) begin
                    cnt_d = '0;
                    ptr_d = (ptr_eff == PTR_LAST) ? '0 : ptr_eff + SEL_W'(1);
                end else begin
                    cnt_d = CNT_LAST;
                end
            end else begin
                cnt_d = cnt_eff + CNT_W'(1);
            end
        end
    end

    // Output register next state: capture wins over consumption.
    always_comb begin
        code_d  = code_q;
        sel_d   = sel_q;
        err_d   = err_q;
        valid_d = valid_q;
        if (valid_q && i_ready) valid_d = 1'b0;
        if (dir_cap) begin
            code_d  = sel_oob ? '0 : sel_code;
            sel_d   = i_sel_code;
            err_d   = sel_oob;
            valid_d = 1'b1;
        end else if (scan_cap) begin
            code_d  = scan_code;
            sel_d   = ptr_eff;
            err_d   = 1'b0;
            valid_d = 1'b1;
        end
        drop_d = (state_cur == DIRECT) && i_load && !slot_free;
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_cur;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

`ifdef CODE_SEL_PARITY_EN
    logic parity_q;

    // Parity is captured together with the code so it follows the same hold rules.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) parity_q <= 1'b0;
        else if (cap) parity_q <= ^code_d;
    end

    assign o_parity = parity_q;
`endif

    assign o_code    = code_q;
    assign o_valid   = valid_q;
    assign o_sel_cur = sel_q;
    assign o_err     = err_q;
    assign o_drop    = drop_q;

endmodule

// File: tb/tb_code_sel_seq.sv
// Directed self-checking bench for code_sel_seq: direct capture, drop,
// scan sequence with wrap, scan stall, async reset and out-of-range select.
module tb_code_sel_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] codes = 32'h20C0_4080;   // ch0..3 = 80, 40, C0, 20

    logic       en = 0, mode = 0, load = 0, ready = 0;
    logic [1:0] sel = 0;
    logic [7:0] code;
    logic       valid, err, drop;
    logic [1:0] sel_cur;

    logic       b_en = 0, b_load = 0, b_ready = 0;
    logic [2:0] b_sel = 0;
    logic [7:0] b_code;
    logic       b_valid, b_err, b_drop;
    logic [2:0] b_sel_cur;

`ifdef CODE_SEL_PARITY_EN
    logic parity, b_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    code_sel_seq #(.N_CODES(4), .CODE_W(8), .SEL_W(2), .DWELL(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_codes(codes),
        .i_sel_code(sel), .i_load(load), .i_ready(ready),
        .o_code(code), .o_valid(valid), .o_sel_cur(sel_cur), .o_err(err),
`ifdef CODE_SEL_PARITY_EN
        .o_parity(parity),
`endif
        .o_drop(drop)
    );

    code_sel_seq #(.N_CODES(4), .CODE_W(8), .SEL_W(3), .DWELL(4)) dut_w3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_mode(1'b0), .i_codes(codes),
        .i_sel_code(b_sel), .i_load(b_load), .i_ready(b_ready),
        .o_code(b_code), .o_valid(b_valid), .o_sel_cur(b_sel_cur), .o_err(b_err),
`ifdef CODE_SEL_PARITY_EN
        .o_parity(b_parity),
`endif
        .o_drop(b_drop)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] scan_exp [5] = '{8'h80, 8'h40, 8'hC0, 8'h20, 8'h80};
    logic       par_exp  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_code", 32'(code), 0);
        check_val("rst_valid", 32'(valid), 0);
        check_val("rst_sel", 32'(sel_cur), 0);
        check_val("rst_err", 32'(err), 0);
        check_val("rst_drop", 32'(drop), 0);
        check_val("rst_b_valid", 32'(b_valid), 0);
`ifdef CODE_SEL_PARITY_EN
        check_val("rst_parity", 32'(parity), 0);
`endif
        step();
        step();
        rst_n = 1'b1;

        // Direct capture of channel 2, consumed on the following edge.
        en = 1; mode = 0; sel = 2; load = 1; ready = 1;
        step();
        load = 0;
        check_val("dir_code", 32'(code), 32'hC0);
        check_val("dir_valid", 32'(valid), 1);
        check_val("dir_sel", 32'(sel_cur), 2);
        check_val("dir_err", 32'(err), 0);
`ifdef CODE_SEL_PARITY_EN
        check_val("dir_parity", 32'(parity), 0);
`endif
        step();
        check_val("dir_consumed", 32'(valid), 0);
        check_val("dir_code_hold", 32'(code), 32'hC0);

        // Second load while the slot is full is dropped.
        ready = 0; sel = 1; load = 1;
        step();
        check_val("drop_first_code", 32'(code), 32'h40);
        check_val("drop_first_pulse", 32'(drop), 0);
        sel = 3;
        step();
        load = 0;
        check_val("drop_pulse", 32'(drop), 1);
        check_val("drop_code_hold", 32'(code), 32'h40);
        check_val("drop_sel_hold", 32'(sel_cur), 1);
        step();
        check_val("drop_once", 32'(drop), 0);
        check_val("drop_valid_hold", 32'(valid), 1);
        ready = 1;
        step();
        check_val("drop_consumed", 32'(valid), 0);

        // Auto-scan with a free slot: one capture every 4 cycles, wrapping.
        mode = 1;
        for (int i = 0; i < 5; i++) begin
            repeat (4) step();
            check_val($sformatf("scan_code%0d", i), 32'(code), 32'(scan_exp[i]));
            check_val($sformatf("scan_sel%0d", i), 32'(sel_cur), i % 4);
            check_val($sformatf("scan_valid%0d", i), 32'(valid), 1);
`ifdef CODE_SEL_PARITY_EN
            check_val($sformatf("scan_parity%0d", i), 32'(parity), 32'(par_exp[i]));
`endif
        end

        // Idle then re-enter scan: pointer restarts; stall while not ready.
        en = 0;
        step();
        check_val("idle_consumed", 32'(valid), 0);
        en = 1;
        repeat (4) step();
        check_val("stall_first", 32'(code), 32'h80);
        check_val("stall_first_sel", 32'(sel_cur), 0);
        ready = 0;
        repeat (10) step();
        check_val("stall_code", 32'(code), 32'h80);
        check_val("stall_valid", 32'(valid), 1);
        ready = 1;
        step();
        check_val("stall_next_code", 32'(code), 32'h40);
        check_val("stall_next_sel", 32'(sel_cur), 1);
        check_val("stall_next_valid", 32'(valid), 1);

        // Asynchronous reset with a pending code, away from any clock edge.
        ready = 0;
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_code", 32'(code), 0);
        check_val("arst_valid", 32'(valid), 0);
        check_val("arst_sel", 32'(sel_cur), 0);
        rst_n = 1'b1;
        ready = 1;
        repeat (4) step();
        check_val("arst_restart_code", 32'(code), 32'h80);
        check_val("arst_restart_sel", 32'(sel_cur), 0);

        // Wider select: out-of-range channel gives zero code and error flag.
        b_en = 1; b_ready = 1; b_sel = 5; b_load = 1;
        step();
        check_val("oob_code", 32'(b_code), 0);
        check_val("oob_err", 32'(b_err), 1);
        check_val("oob_sel", 32'(b_sel_cur), 5);
        check_val("oob_valid", 32'(b_valid), 1);
        b_sel = 0;
        step();
        b_load = 0;
        check_val("inr_code", 32'(b_code), 32'h80);
        check_val("inr_err", 32'(b_err), 0);
        check_val("inr_drop", 32'(b_drop), 0);
        step();
        check_val("inr_consumed", 32'(b_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
